// File: rtl/output_store_pkg.sv
// Shared types, widths and the array-column to mux-select mapping
// used by the output-path sequencer.
package output_store_pkg;

  localparam int NUMBER_MUX_OUT_1         = 4;
  localparam int NUMBER_INPUT_MUX_OUT_1   = 4;
  localparam int N_COLS_ARRAY             = NUMBER_MUX_OUT_1 * NUMBER_INPUT_MUX_OUT_1;
  localparam int SEL_WIDTH_MUX_OUT_1      = 2;
  localparam int SEL_WIDTH_MUX_OUT_2      = 2;
  localparam int NUMBER_SUPPORTED_FILTERS = 30;
  localparam int FILT_WIDTH               = $clog2(NUMBER_SUPPORTED_FILTERS);
  localparam int BRAM_ADDR_WIDTH          = 11;
  localparam int COL_WIDTH                = $clog2(N_COLS_ARRAY);
  localparam int M_WIDTH                  = FILT_WIDTH + 1;
  localparam int CNT_WIDTH                = BRAM_ADDR_WIDTH + 1;

  typedef enum logic [2:0] {IDLE, CONFIG, CAPTURE, ISSUE, WAIT, OUT} state_t;

  typedef struct packed {
    logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_2;
    logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_1;
  } sel_t;

  // Low bits pick the input within a first-level mux, high bits pick the mux.
  function automatic sel_t col_to_sel(input logic [COL_WIDTH-1:0] col);
    sel_t s;
    s.sel_1 = col[SEL_WIDTH_MUX_OUT_1-1:0];
    s.sel_2 = col[COL_WIDTH-1 -: SEL_WIDTH_MUX_OUT_2];
    return s;
  endfunction

endpackage

// File: rtl/output_store_ctrl_sel_shifter.sv
// CONFIG-phase down-counter: emits one column select per filter,
// last filter first, so filter k ends up at chain position k.
module output_sel_shifter
  import output_store_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           load_i,
  input  logic                           active_i,
  input  logic [M_WIDTH-1:0]             n_filters_i,
  input  logic [COL_WIDTH-1:0]           col_offset_i,
  output logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_1_o,
  output logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_2_o,
  output logic                           ld_o,
  output logic                           last_o
);

  logic [M_WIDTH-1:0]   k_q, k_d;
  logic [COL_WIDTH-1:0] off_q, off_d;
  logic [COL_WIDTH-1:0] col;
  sel_t                 sel;

  always_comb begin
    k_d   = k_q;
    off_d = off_q;
    if (load_i) begin
      k_d   = n_filters_i - M_WIDTH'(1);
      off_d = col_offset_i;
    end else if (active_i && (k_q != '0)) begin
      k_d = k_q - M_WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      k_q   <= '0;
      off_q <= '0;
    end else begin
      k_q   <= k_d;
      off_q <= off_d;
    end
  end

  // Truncating add gives the modulo-16 wrap for M > 16.
  assign col     = off_q + k_q[COL_WIDTH-1:0];
  assign sel     = col_to_sel(col);
  assign sel_1_o = active_i ? sel.sel_1 : '0;
  assign sel_2_o = active_i ? sel.sel_2 : '0;
  assign ld_o    = active_i;
  assign last_o  = (k_q == '0);

endmodule

// File: rtl/output_store_ctrl.sv
// Output-path sequencer: configures the select chain, captures array
// results into BRAM, then streams them out filter by filter.
module output_store_ctrl
  import output_store_pkg::*;
(
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           start_i,
  input  logic [FILT_WIDTH:0]            n_filters_i,
  input  logic [COL_WIDTH-1:0]           col_offset_i,
  input  logic [BRAM_ADDR_WIDTH:0]       n_pixels_i,
  input  logic [BRAM_ADDR_WIDTH-1:0]     base_addr_i,
  input  logic                           res_valid_i,
  input  logic                           out_ready_i,
  output logic [SEL_WIDTH_MUX_OUT_1-1:0] sel_mux_out_1_o,
  output logic [SEL_WIDTH_MUX_OUT_2-1:0] sel_mux_out_2_o,
  output logic                           sel_mux_out_ld_o,
  output logic                           sel_mux_out_rst_o,
  output logic                           mux_out_reg_rst_o,
  output logic                           bram_rst_o,
  output logic                           mux_out_reg_wr_en_o,
  output logic                           bram_wr_en_a_o,
  output logic                           bram_wr_en_b_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_write_read_o,
  output logic [BRAM_ADDR_WIDTH-1:0]     bram_addr_read_write_o,
  output logic [FILT_WIDTH-1:0]          sel_mux_final_o,
  output logic                           out_valid_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           overrun_o
);

  state_t                     state_q, state_d;
  logic [M_WIDTH-1:0]         m_q, m_d;
  logic [CNT_WIDTH-1:0]       n_pix_q, n_pix_d;
  logic [BRAM_ADDR_WIDTH-1:0] base_q, base_d;
  logic [BRAM_ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_WIDTH-1:0]       count_q, count_d;
  logic [M_WIDTH-1:0]         f_q, f_d;
  logic [CNT_WIDTH-1:0]       p_q, p_d;
  logic                       done_q, done_d;
  logic                       overrun_q, overrun_d;
  logic                       cap_pend_q;
  logic                       start_acc;
  logic                       accept;
  logic                       sel_last;

  // Accepted-but-not-yet-written results count toward P so no extra pixel slips in.
  assign start_acc = (state_q == IDLE) && start_i;
  assign accept    = (state_q == CAPTURE) && res_valid_i &&
                     (({1'b0, count_q} + (CNT_WIDTH+1)'(cap_pend_q)) < {1'b0, n_pix_q});

  output_sel_shifter u_sel_shifter (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_i       (start_acc),
    .active_i     (state_q == CONFIG),
    .n_filters_i  (n_filters_i),
    .col_offset_i (col_offset_i),
    .sel_1_o      (sel_mux_out_1_o),
    .sel_2_o      (sel_mux_out_2_o),
    .ld_o         (sel_mux_out_ld_o),
    .last_o       (sel_last)
  );

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    n_pix_d   = n_pix_q;
    base_d    = base_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    f_d       = f_q;
    p_d       = p_q;
    done_d    = 1'b0;
    overrun_d = overrun_q | (res_valid_i & ~accept);
    case (state_q)
      IDLE: begin
        if (start_i) begin
          m_d      = n_filters_i;
          n_pix_d  = n_pixels_i;
          base_d   = base_addr_i;
          wr_ptr_d = base_addr_i;
          count_d  = '0;
          f_d      = '0;
          p_d      = '0;
          if ((n_filters_i == '0) || (n_pixels_i == '0)) begin
            done_d = 1'b1;
          end else begin
            state_d = CONFIG;
          end
        end
      end
      CONFIG: begin
        if (sel_last) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (cap_pend_q) begin
          wr_ptr_d = wr_ptr_q + BRAM_ADDR_WIDTH'(1);
          count_d  = count_q + CNT_WIDTH'(1);
          if ((count_q + CNT_WIDTH'(1)) == n_pix_q) state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT:  state_d = OUT;
      OUT: begin
        if (out_ready_i) begin
          if (p_q == (n_pix_q - CNT_WIDTH'(1))) begin
            p_d = '0;
            if (f_q == (m_q - M_WIDTH'(1))) begin
              f_d     = '0;
              done_d  = 1'b1;
              state_d = IDLE;
            end else begin
              f_d     = f_q + M_WIDTH'(1);
              state_d = ISSUE;
            end
          end else begin
            p_d     = p_q + CNT_WIDTH'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= IDLE;
      m_q        <= '0;
      n_pix_q    <= '0;
      base_q     <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      f_q        <= '0;
      p_q        <= '0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      cap_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      n_pix_q    <= n_pix_d;
      base_q     <= base_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      f_q        <= f_d;
      p_q        <= p_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      cap_pend_q <= accept;
    end
  end

  assign sel_mux_out_rst_o      = start_acc;
  assign mux_out_reg_rst_o      = start_acc;
  assign bram_rst_o             = start_acc;
  assign mux_out_reg_wr_en_o    = accept;
  assign bram_wr_en_a_o         = cap_pend_q;
  assign bram_wr_en_b_o         = 1'b0;
  assign bram_addr_write_read_o = wr_ptr_q;
  assign bram_addr_read_write_o = base_q + p_q[BRAM_ADDR_WIDTH-1:0];
  assign sel_mux_final_o        = f_q[FILT_WIDTH-1:0];
  assign out_valid_o            = (state_q == OUT);
  assign busy_o                 = (state_q != IDLE);
  assign done_o                 = done_q;
  assign overrun_o              = overrun_q;

endmodule

// File: tb/tb_output_store_ctrl.sv
// Directed bench for output_store_ctrl with write/read scoreboards.
module tb_output_store_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [5:0]  n_filters_i;
  logic [3:0]  col_offset_i;
  logic [11:0] n_pixels_i;
  logic [10:0] base_addr_i;
  logic        res_valid_i;
  logic        out_ready_i;
  logic [1:0]  sel_mux_out_1_o;
  logic [1:0]  sel_mux_out_2_o;
  logic        sel_mux_out_ld_o;
  logic        sel_mux_out_rst_o;
  logic        mux_out_reg_rst_o;
  logic        bram_rst_o;
  logic        mux_out_reg_wr_en_o;
  logic        bram_wr_en_a_o;
  logic        bram_wr_en_b_o;
  logic [10:0] bram_addr_write_read_o;
  logic [10:0] bram_addr_read_write_o;
  logic [4:0]  sel_mux_final_o;
  logic        out_valid_o;
  logic        busy_o;
  logic        done_o;
  logic        overrun_o;

  typedef struct {
    logic [10:0] addr;
    logic [4:0]  sel;
  } rd_t;

  rd_t         rd_q[$];
  logic [10:0] wr_q[$];
  int          total = 0;
  int          bad   = 0;

  output_store_ctrl dut (
    .clk_i                  (clk_i),
    .rst_n_i                (rst_n_i),
    .start_i                (start_i),
    .n_filters_i            (n_filters_i),
    .col_offset_i           (col_offset_i),
    .n_pixels_i             (n_pixels_i),
    .base_addr_i            (base_addr_i),
    .res_valid_i            (res_valid_i),
    .out_ready_i            (out_ready_i),
    .sel_mux_out_1_o        (sel_mux_out_1_o),
    .sel_mux_out_2_o        (sel_mux_out_2_o),
    .sel_mux_out_ld_o       (sel_mux_out_ld_o),
    .sel_mux_out_rst_o      (sel_mux_out_rst_o),
    .mux_out_reg_rst_o      (mux_out_reg_rst_o),
    .bram_rst_o             (bram_rst_o),
    .mux_out_reg_wr_en_o    (mux_out_reg_wr_en_o),
    .bram_wr_en_a_o         (bram_wr_en_a_o),
    .bram_wr_en_b_o         (bram_wr_en_b_o),
    .bram_addr_write_read_o (bram_addr_write_read_o),
    .bram_addr_read_write_o (bram_addr_read_write_o),
    .sel_mux_final_o        (sel_mux_final_o),
    .out_valid_o            (out_valid_o),
    .busy_o                 (busy_o),
    .done_o                 (done_o),
    .overrun_o              (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {sel_mux_out_1_o, sel_mux_out_2_o, sel_mux_out_ld_o, sel_mux_out_rst_o,
              mux_out_reg_rst_o, bram_rst_o, mux_out_reg_wr_en_o, bram_wr_en_a_o,
              bram_wr_en_b_o, bram_addr_write_read_o, bram_addr_read_write_o,
              sel_mux_final_o, out_valid_o, busy_o, done_o, overrun_o}, 64'd0);
  endtask

  // Start cycle, then either the empty-job done pulse or the CONFIG select sequence.
  task automatic do_start(input int m, input int off, input int p, input int b);
    int c;
    start_i = 1'b1; n_filters_i = 6'(m); col_offset_i = 4'(off);
    n_pixels_i = 12'(p); base_addr_i = 11'(b);
    @(negedge clk_i);
    chk("start_sel_rst", sel_mux_out_rst_o, 1);
    chk("start_reg_rst", mux_out_reg_rst_o, 1);
    chk("start_bram_rst", bram_rst_o, 1);
    chk("start_busy", busy_o, 0);
    next_cyc();
    start_i = 1'b0;
    if (m == 0 || p == 0) begin
      @(negedge clk_i);
      chk("empty_done", done_o, 1);
      chk("empty_ld", sel_mux_out_ld_o, 0);
      chk("empty_busy", busy_o, 0);
      next_cyc();
      @(negedge clk_i);
      chk("empty_done_pulse", done_o, 0);
      next_cyc();
    end else begin
      for (int i = 0; i < m; i++) begin
        c = (off + (m - 1 - i)) % 16;
        @(negedge clk_i);
        chk("cfg_ld", sel_mux_out_ld_o, 1);
        chk("cfg_sel1", sel_mux_out_1_o, c % 4);
        chk("cfg_sel2", sel_mux_out_2_o, c / 4);
        chk("cfg_done", done_o, 0);
        next_cyc();
      end
    end
  endtask

  // Drives res_valid_i from mask bits; each accepted pixel expects a write one cycle later.
  task automatic do_capture(input int mask, input int len, input int b);
    logic v, prev;
    int   nacc;
    logic [10:0] exp_a;
    prev = 1'b0; nacc = 0;
    for (int i = 0; i <= len; i++) begin
      v = (i < len) ? mask[i] : 1'b0;
      res_valid_i = v;
      @(negedge clk_i);
      chk("cap_ld", sel_mux_out_ld_o, 0);
      chk("cap_mux_wr", mux_out_reg_wr_en_o, v);
      chk("cap_wr_en", bram_wr_en_a_o, prev);
      if (bram_wr_en_a_o) begin
        exp_a = (wr_q.size() > 0) ? wr_q.pop_front() : 11'h7ff;
        chk("cap_wr_addr", bram_addr_write_read_o, exp_a);
      end
      if (v) begin
        wr_q.push_back(11'(b + nacc));
        nacc++;
      end
      prev = v;
      next_cyc();
    end
    res_valid_i = 1'b0;
  endtask

  task automatic push_reads(input int m, input int p, input int b);
    rd_t r;
    for (int f = 0; f < m; f++) begin
      for (int q = 0; q < p; q++) begin
        r.addr = 11'(b + q);
        r.sel  = 5'(f);
        rd_q.push_back(r);
      end
    end
  endtask

  task automatic do_read(input int n, input int stall_idx, input int stall_len);
    int  xf, gap, stalls, stalls_elem, cyc;
    bit  seen_done;
    rd_t head;
    xf = 0; gap = 0; stalls = 0; stalls_elem = 0; cyc = 0; seen_done = 0;
    while (!seen_done && cyc < 2000) begin
      out_ready_i = !(xf == stall_idx && stalls < stall_len);
      @(negedge clk_i);
      gap++;
      if (done_o) begin
        seen_done = 1;
        chk("rd_xfers_at_done", xf, n);
        chk("rd_queue_empty", rd_q.size(), 0);
        chk("rd_busy_at_done", busy_o, 0);
      end else if (out_valid_o) begin
        head.addr = 11'h7ff; head.sel = 5'h1f;
        if (rd_q.size() > 0) head = rd_q[0];
        chk("rd_addr", bram_addr_read_write_o, head.addr);
        chk("rd_sel", sel_mux_final_o, head.sel);
        if (out_ready_i) begin
          if (rd_q.size() > 0) void'(rd_q.pop_front());
          chk("rd_gap", gap, 3 + stalls_elem);
          $display("xfer %0d addr=%0h sel=%0d gap=%0d", xf, bram_addr_read_write_o, sel_mux_final_o, gap);
          xf++; gap = 0; stalls_elem = 0;
        end else begin
          stalls++; stalls_elem++;
        end
      end
      cyc++;
      next_cyc();
    end
    chk("rd_done_seen", seen_done, 1);
    out_ready_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0; start_i = 1'b0; n_filters_i = '0; col_offset_i = '0;
    n_pixels_i = '0; base_addr_i = '0; res_valid_i = 1'b0; out_ready_i = 1'b0;
    #2;
    chk_all_zero("reset_state");
    next_cyc(); next_cyc();
    rst_n_i = 1'b1;
    next_cyc();

    // Run 1: M=2, offset 3, P=4, base 0x10, ready always high.
    do_start(2, 3, 4, 'h10);
    do_capture('b1111, 4, 'h10);
    push_reads(2, 4, 'h10);
    out_ready_i = 1'b1;
    do_read(8, -1, 0);
    chk("run1_overrun", overrun_o, 0);

    // Run 2: M=17 wraps columns, base 0x7ff wraps addresses, stall 5 cycles.
    do_start(17, 14, 2, 'h7ff);
    do_capture('b101, 3, 'h7ff);
    push_reads(17, 2, 'h7ff);
    do_read(34, 1, 5);
    chk("run2_overrun", overrun_o, 0);

    // Empty jobs, then a stray result in IDLE.
    do_start(0, 7, 4, 'h20);
    do_start(3, 0, 0, 'h20);
    res_valid_i = 1'b1;
    @(negedge clk_i);
    chk("idle_mux_wr", mux_out_reg_wr_en_o, 0);
    chk("idle_overrun_before", overrun_o, 0);
    next_cyc();
    res_valid_i = 1'b0;
    @(negedge clk_i);
    chk("idle_overrun_after", overrun_o, 1);
    chk("idle_busy", busy_o, 0);
    next_cyc();

    // Reset in CAPTURE after two writes.
    do_start(1, 0, 4, 'h100);
    do_capture('b11, 2, 'h100);
    chk("pre_reset_busy", busy_o, 1);
    rst_n_i = 1'b0;
    #1;
    chk_all_zero("midrun_reset");
    next_cyc();
    rst_n_i = 1'b1;
    @(negedge clk_i);
    chk("post_reset_busy", busy_o, 0);
    chk("post_reset_done", done_o, 0);
    chk("post_reset_overrun", overrun_o, 0);
    next_cyc();
    wr_q.delete();

    // Run 4: normal run after abort.
    do_start(2, 5, 3, 'h3);
    do_capture('b10101, 5, 'h3);
    push_reads(2, 3, 'h3);
    out_ready_i = 1'b1;
    do_read(6, -1, 0);
    chk("run4_wr_queue_empty", wr_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
